// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush-driven bubble
// insertion and a saturating count of bubbles inserted since reset.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        regDst,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        memToReg,
    input  logic        regWrite,
    input  logic        aluSrc,
    input  logic        jump,
    input  logic [1:0]  aluOp,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rdata1,
    input  logic [31:0] id_rdata2,
    input  logic [31:0] id_imm,
    input  logic [31:0] id_pc4,
    input  logic        flush,
    output logic        stall,
    output logic        ex_regDst,
    output logic        ex_branch_eq,
    output logic        ex_branch_ne,
    output logic        ex_memRead,
    output logic        ex_memWrite,
    output logic        ex_memToReg,
    output logic        ex_regWrite,
    output logic        ex_aluSrc,
    output logic        ex_jump,
    output logic [1:0]  ex_aluOp,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic [31:0] ex_rdata1,
    output logic [31:0] ex_rdata2,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_pc4,
    output logic        ex_valid,
    output logic [15:0] bubble_cnt
);

    localparam int unsigned CTRL_W = 11;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WORD_W = CTRL_W + 3 * REG_W + 4 * DATA_W;
    localparam int unsigned CNT_W  = 16;

    logic              use_rs;
    logic              use_rt;
    logic              rs_match;
    logic              rt_match;
    logic              load_bubble;
    logic [WORD_W-1:0] id_word;
    logic [WORD_W-1:0] ex_word;

    // Operand usage of the ID instruction: jumps read no rs, immediates read no rt except stores
    assign use_rs   = ~jump;
    assign use_rt   = ~aluSrc | memWrite;
    assign rs_match = use_rs & (ex_rt == id_rs);
    assign rt_match = use_rt & (ex_rt == id_rt);

    // Load-use hazard; a flush discards the ID instruction so no stall is needed
    assign stall = ex_valid & ex_memRead & (ex_rt != REG_W'(0))
                 & (rs_match | rt_match) & ~flush;

    assign load_bubble = flush | stall;

    assign id_word = {regDst, branch_eq, branch_ne, memRead, memWrite, memToReg,
                      regWrite, aluSrc, jump, aluOp,
                      id_rs, id_rt, id_rd,
                      id_rdata1, id_rdata2, id_imm, id_pc4};

    // Pipeline register: capture the ID word or insert an all-zero bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_word    <= '0;
            ex_valid   <= 1'b0;
            bubble_cnt <= '0;
        end else if (load_bubble) begin
            ex_word  <= '0;
            ex_valid <= 1'b0;
            if (bubble_cnt != {CNT_W{1'b1}}) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end else begin
            ex_word  <= id_word;
            ex_valid <= 1'b1;
        end
    end

    assign {ex_regDst, ex_branch_eq, ex_branch_ne, ex_memRead, ex_memWrite, ex_memToReg,
            ex_regWrite, ex_aluSrc, ex_jump, ex_aluOp,
            ex_rs, ex_rt, ex_rd,
            ex_rdata1, ex_rdata2, ex_imm, ex_pc4} = ex_word;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage: pass-through, load-use stalls,
// register-0 and operand-usage filtering, flush priority, reset and saturation.
module tb_id_ex_stage;

    localparam int unsigned WORD_W = 154;

    // Control shorthand: {regDst, memRead, memWrite, regWrite, aluSrc, jump, aluOp[1:0]}
    localparam logic [7:0] OP_ADD  = 8'b1_0_0_1_0_0_10;
    localparam logic [7:0] OP_LW   = 8'b0_1_0_1_1_0_00;
    localparam logic [7:0] OP_SW   = 8'b0_0_1_0_1_0_00;
    localparam logic [7:0] OP_ADDI = 8'b0_0_0_1_1_0_00;
    localparam logic [7:0] OP_J    = 8'b0_0_0_0_0_1_00;

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [31:0] d1;
        logic        fl;
        logic        exp_stall;
        logic        exp_cap;
        logic [4:0]  exp_rt, exp_rd;
        logic [31:0] exp_d1;
        logic        exp_mr;
        logic [15:0] exp_cnt;
    } vec_t;

    logic        clk, rst_n;
    logic        regDst, branch_eq, branch_ne, memRead, memWrite, memToReg;
    logic        regWrite, aluSrc, jump;
    logic [1:0]  aluOp;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rdata1, id_rdata2, id_imm, id_pc4;
    logic        flush, stall;
    logic        ex_regDst, ex_branch_eq, ex_branch_ne, ex_memRead, ex_memWrite;
    logic        ex_memToReg, ex_regWrite, ex_aluSrc, ex_jump;
    logic [1:0]  ex_aluOp;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
    logic        ex_valid;
    logic [15:0] bubble_cnt;

    logic [WORD_W-1:0] in_word, ex_word;
    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl[$];

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .regDst(regDst), .branch_eq(branch_eq), .branch_ne(branch_ne),
        .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
        .regWrite(regWrite), .aluSrc(aluSrc), .jump(jump), .aluOp(aluOp),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc4(id_pc4),
        .flush(flush), .stall(stall),
        .ex_regDst(ex_regDst), .ex_branch_eq(ex_branch_eq), .ex_branch_ne(ex_branch_ne),
        .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite), .ex_memToReg(ex_memToReg),
        .ex_regWrite(ex_regWrite), .ex_aluSrc(ex_aluSrc), .ex_jump(ex_jump),
        .ex_aluOp(ex_aluOp), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .ex_valid(ex_valid), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign in_word = {regDst, branch_eq, branch_ne, memRead, memWrite, memToReg,
                      regWrite, aluSrc, jump, aluOp, id_rs, id_rt, id_rd,
                      id_rdata1, id_rdata2, id_imm, id_pc4};
    assign ex_word = {ex_regDst, ex_branch_eq, ex_branch_ne, ex_memRead, ex_memWrite,
                      ex_memToReg, ex_regWrite, ex_aluSrc, ex_jump, ex_aluOp,
                      ex_rs, ex_rt, ex_rd, ex_rdata1, ex_rdata2, ex_imm, ex_pc4};

    task automatic check(input string name, input logic [WORD_W-1:0] act,
                         input logic [WORD_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Remaining fields are derived from d1 so every bit of the word moves between vectors
    task automatic drive(input logic [7:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] d1, input logic fl);
        {regDst, memRead, memWrite, regWrite, aluSrc, jump, aluOp} = op;
        memToReg  = op[6];
        branch_eq = d1[0];
        branch_ne = d1[1];
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rdata1 = d1;
        id_rdata2 = d1 + 32'd100;
        id_imm    = ~d1;
        id_pc4    = {d1[29:0], 2'b00} + 32'd4;
        flush = fl;
    endtask

    function automatic vec_t mk(input string name, input logic [7:0] op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] d1,
                                input logic fl, input logic es, input logic ec,
                                input logic [4:0] ert, input logic [4:0] erd,
                                input logic [31:0] ed1, input logic emr, input logic [15:0] ecnt);
        vec_t v;
        v.name = name; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.d1 = d1; v.fl = fl;
        v.exp_stall = es; v.exp_cap = ec; v.exp_rt = ert; v.exp_rd = erd;
        v.exp_d1 = ed1; v.exp_mr = emr; v.exp_cnt = ecnt;
        return v;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_word"},  WORD_W'(ex_word),    WORD_W'(0));
        check({tag, "_valid"}, WORD_W'(ex_valid),   WORD_W'(0));
        check({tag, "_cnt"},   WORD_W'(bubble_cnt), WORD_W'(0));
        check({tag, "_stall"}, WORD_W'(stall),      WORD_W'(0));
    endtask

    initial begin
        //          name       op       rs  rt  rd  d1  fl st cap ert erd ed1 mr cnt
        tbl.push_back(mk("add_pass", OP_ADD,  1,  2,  3,  5, 0, 0, 1, 2, 3,  5, 0, 0));
        tbl.push_back(mk("lw_rt4",   OP_LW,   1,  4,  0,  8, 0, 0, 1, 4, 0,  8, 1, 0));
        tbl.push_back(mk("add_haz",  OP_ADD,  4,  5,  6,  9, 0, 1, 0, 0, 0,  0, 0, 1));
        tbl.push_back(mk("add_held", OP_ADD,  4,  5,  6,  9, 0, 0, 1, 5, 6,  9, 0, 1));
        tbl.push_back(mk("lw_rt4b",  OP_LW,   1,  4,  0, 10, 0, 0, 1, 4, 0, 10, 1, 1));
        tbl.push_back(mk("addi_rt4", OP_ADDI, 7,  4,  0, 11, 0, 0, 1, 4, 0, 11, 0, 1));
        tbl.push_back(mk("lw_rt4c",  OP_LW,   2,  4,  0, 12, 0, 0, 1, 4, 0, 12, 1, 1));
        tbl.push_back(mk("sw_haz",   OP_SW,   7,  4,  0, 13, 0, 1, 0, 0, 0,  0, 0, 2));
        tbl.push_back(mk("sw_held",  OP_SW,   7,  4,  0, 13, 0, 0, 1, 4, 0, 13, 0, 2));
        tbl.push_back(mk("lw_rt0",   OP_LW,   3,  0,  0, 14, 0, 0, 1, 0, 0, 14, 1, 2));
        tbl.push_back(mk("add_r0",   OP_ADD,  0,  0,  3, 15, 0, 0, 1, 0, 3, 15, 0, 2));
        tbl.push_back(mk("lw_rt4d",  OP_LW,   1,  4,  0, 16, 0, 0, 1, 4, 0, 16, 1, 2));
        tbl.push_back(mk("flush_hz", OP_ADD,  4,  5,  6, 17, 1, 0, 0, 0, 0,  0, 0, 3));
        tbl.push_back(mk("lw_rt4e",  OP_LW,   1,  4,  0, 18, 0, 0, 1, 4, 0, 18, 1, 3));
        tbl.push_back(mk("jump_rs4", OP_J,    4,  9,  0, 19, 0, 0, 1, 9, 0, 19, 0, 3));
        tbl.push_back(mk("flush_pl", OP_ADD,  1,  2,  3, 20, 1, 0, 0, 0, 0,  0, 0, 4));

        rst_n = 1'b0;
        drive(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 1'b0);
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].d1, tbl[i].fl);
            #1 check({tbl[i].name, "_stall"}, WORD_W'(stall), WORD_W'(tbl[i].exp_stall));
            @(posedge clk);
            #1;
            check({tbl[i].name, "_word"}, ex_word, tbl[i].exp_cap ? in_word : WORD_W'(0));
            check({tbl[i].name, "_valid"}, WORD_W'(ex_valid), WORD_W'(tbl[i].exp_cap));
            check({tbl[i].name, "_rt"}, WORD_W'(ex_rt), WORD_W'(tbl[i].exp_rt));
            check({tbl[i].name, "_rd"}, WORD_W'(ex_rd), WORD_W'(tbl[i].exp_rd));
            check({tbl[i].name, "_rdata1"}, WORD_W'(ex_rdata1), WORD_W'(tbl[i].exp_d1));
            check({tbl[i].name, "_memrd"}, WORD_W'(ex_memRead), WORD_W'(tbl[i].exp_mr));
            check({tbl[i].name, "_cnt"}, WORD_W'(bubble_cnt), WORD_W'(tbl[i].exp_cnt));
        end

        // Reset asserted mid-cycle while a load-use hazard is pending
        @(negedge clk);
        drive(OP_LW, 5'd1, 5'd4, 5'd0, 32'd30, 1'b0);
        @(negedge clk);
        drive(OP_ADD, 5'd4, 5'd5, 5'd6, 32'd31, 1'b0);
        #1 check("midrst_pre_stall", WORD_W'(stall), WORD_W'(1));
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        @(posedge clk);
        #1 check_zero("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rel_stall", WORD_W'(stall), WORD_W'(0));
        @(posedge clk);
        #1;
        check("rel_word", ex_word, in_word);
        check("rel_valid", WORD_W'(ex_valid), WORD_W'(1));
        check("rel_cnt", WORD_W'(bubble_cnt), WORD_W'(0));

        // Saturation: 65535 flushed edges reach the ceiling, one more must not wrap
        @(negedge clk);
        flush = 1'b1;
        repeat (65534) @(posedge clk);
        #1 check("cnt_fffe", WORD_W'(bubble_cnt), WORD_W'(16'hFFFE));
        @(posedge clk);
        #1 check("cnt_ffff", WORD_W'(bubble_cnt), WORD_W'(16'hFFFF));
        @(posedge clk);
        #1 check("cnt_sat", WORD_W'(bubble_cnt), WORD_W'(16'hFFFF));
        check("sat_word", ex_word, WORD_W'(0));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("sat_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
